// File: rtl/reg_file_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_dump_ctrl
// Description : Scans the architectural state (GPR x0..x31, then edge-
//               collision registers e0..e5) out over a valid/ready stream.
//               It borrows the shared register read ports. The core keeps
//               priority, but a scan is starved for at most STARVE_MAX cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dump_ctrl #(
    parameter int NUM_GPR    = 32,
    parameter int NUM_ECR    = 6,
    parameter int GPR_WIDTH  = 32,
    parameter int ECR_WIDTH  = 34,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 core_rd_req,
    output logic                 core_gnt,
    output logic                 gpr_rd_en,
    output logic [4:0]           gpr_rd_addr,
    input  logic [GPR_WIDTH-1:0] gpr_rd_data,
    output logic                 ecr_rd_en,
    output logic [2:0]           ecr_rd_addr,
    input  logic [ECR_WIDTH-1:0] ecr_rd_data,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [5:0]           dump_index,
    output logic [ECR_WIDTH-1:0] dump_data
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam int                 c_PAD        = ECR_WIDTH - GPR_WIDTH;
    localparam logic [5:0]         c_NUM_GPR    = 6'(NUM_GPR);
    localparam logic [5:0]         c_LAST_IDX   = 6'(NUM_GPR + NUM_ECR - 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [5:0]             r_idx;
    logic [c_CNT_W-1:0]     r_starve;
    logic [ECR_WIDTH-1:0]   r_dump_data;
    logic [5:0]             r_dump_index;

    logic                   w_is_gpr;
    logic                   w_last;
    logic                   w_handshake;
    logic [2:0]             w_ecr_addr;
    logic [ECR_WIDTH-1:0]   w_gpr_ext;

    assign w_is_gpr    = (r_idx < c_NUM_GPR);
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_handshake = (r_state == S_HOLD) && dump_ready;
    // Modulo-8 subtraction is exact because the ECR offset fits in 3 bits.
    assign w_ecr_addr  = r_idx[2:0] - c_NUM_GPR[2:0];
    assign w_gpr_ext   = {{c_PAD{1'b0}}, gpr_rd_data};

    // State register; reset discards any scan in progress.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort from any active state wins over everything.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && !abort) w_next = S_ARB;
            S_ARB: begin
                if (abort)                                          w_next = S_IDLE;
                else if (!core_rd_req || (r_starve == c_STARVE_MAX)) w_next = S_RD;
            end
            S_RD:   w_next = abort ? S_IDLE : S_WAIT;
            S_WAIT: w_next = abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (abort)            w_next = S_IDLE;
                else if (w_handshake) w_next = w_last ? S_FIN : S_ARB;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Scan index, starvation counter and captured beat.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_idx        <= '0;
            r_starve     <= '0;
            r_dump_data  <= '0;
            r_dump_index <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_idx <= '0;
            end else if (w_handshake && !abort && !w_last) begin
                r_idx <= r_idx + 6'd1;
            end

            // Staying in ARB means the core held the port and the limit is not yet hit.
            if ((r_state == S_ARB) && (w_next == S_ARB)) begin
                r_starve <= r_starve + c_CNT_ONE;
            end else begin
                r_starve <= '0;
            end

            if (r_state == S_WAIT) begin
                r_dump_data  <= w_is_gpr ? w_gpr_ext : ecr_rd_data;
                r_dump_index <= r_idx;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign core_gnt    = (r_state != S_RD);
    assign gpr_rd_en   = (r_state == S_RD) && w_is_gpr;
    assign gpr_rd_addr = gpr_rd_en ? r_idx[4:0] : 5'd0;
    assign ecr_rd_en   = (r_state == S_RD) && !w_is_gpr;
    assign ecr_rd_addr = ecr_rd_en ? w_ecr_addr : 3'd0;
    assign dump_valid  = (r_state == S_HOLD);
    assign dump_index  = r_dump_index;
    assign dump_data   = r_dump_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_dump_ctrl
// Description : Self-checking bench for reg_file_dump_ctrl. Register files are
//               modelled as arrays, and beats are collected by a monitor and
//               compared with the expected register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_dump_ctrl;

    localparam int c_NREG   = 38;
    localparam int c_STARVE = 8;

    logic        clk;
    logic        rstb;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        core_rd_req;
    logic        core_gnt;
    logic        gpr_rd_en;
    logic [4:0]  gpr_rd_addr;
    logic [31:0] gpr_rd_data;
    logic        ecr_rd_en;
    logic [2:0]  ecr_rd_addr;
    logic [33:0] ecr_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [5:0]  dump_index;
    logic [33:0] dump_data;

    logic [31:0] gpr_mem [32];
    logic [33:0] ecr_mem [8];

    logic rdy_fixed, rdy_rand_en, rnd_rdy;
    logic req_fixed, req_rand_en, rnd_req;
    assign dump_ready  = rdy_rand_en ? rnd_rdy : rdy_fixed;
    assign core_rd_req = req_rand_en ? rnd_req : req_fixed;

    int errors = 0;
    int checks = 0;

    reg_file_dump_ctrl dut (
        .clk         (clk),
        .rstb        (rstb),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .core_rd_req (core_rd_req),
        .core_gnt    (core_gnt),
        .gpr_rd_en   (gpr_rd_en),
        .gpr_rd_addr (gpr_rd_addr),
        .gpr_rd_data (gpr_rd_data),
        .ecr_rd_en   (ecr_rd_en),
        .ecr_rd_addr (ecr_rd_addr),
        .ecr_rd_data (ecr_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_index  (dump_index),
        .dump_data   (dump_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file models: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        gpr_rd_data <= gpr_rd_en ? gpr_mem[gpr_rd_addr] : $urandom;
        ecr_rd_data <= ecr_rd_en ? ecr_mem[ecr_rd_addr] : {2'b11, $urandom};
    end

    // Random ready / request sources, refreshed just after every rising edge.
    always @(posedge clk) begin
        #1;
        rnd_rdy <= 1'($urandom_range(0, 1));
        rnd_req <= 1'($urandom_range(0, 1));
    end

    // Monitor: collects beats and protocol statistics on the falling edge.
    logic [5:0]  got_idx  [1024];
    logic [33:0] got_data [1024];
    int n_beats = 0, done_cnt = 0, gnt_low = 0, cyc = 0;
    int start_cyc = 0, done_cyc = 0;
    int stab_err = 0, hold_gnt_err = 0, gnt_rd_err = 0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_idx = '0;
    logic [33:0] prev_data = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rstb) begin
            if (dump_valid && dump_ready) begin
                got_idx[n_beats]  <= dump_index;
                got_data[n_beats] <= dump_data;
                n_beats           <= n_beats + 1;
            end
            if (prev_stall && dump_valid && ((dump_index !== prev_idx) || (dump_data !== prev_data)))
                stab_err <= stab_err + 1;
            prev_stall <= dump_valid && !dump_ready;
            prev_idx   <= dump_index;
            prev_data  <= dump_data;
            if (!core_gnt) gnt_low <= gnt_low + 1;
            if (dump_valid && !core_gnt) hold_gnt_err <= hold_gnt_err + 1;
            if ((!core_gnt) !== (gpr_rd_en || ecr_rd_en)) gnt_rd_err <= gnt_rd_err + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (start && !abort && !busy) start_cyc <= cyc;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] exp_val(input int i);
        if (i < 32) return {2'b00, gpr_mem[i]};
        return ecr_mem[i - 32];
    endfunction

    task automatic randomize_regs;
        for (int i = 0; i < 32; i++) gpr_mem[i] = $urandom;
        for (int k = 0; k < 8; k++) ecr_mem[k] = {2'($urandom_range(0, 3)), $urandom};
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick;
        chk({tag, "_done_single"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_valid_idx(input logic [5:0] target);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (dump_valid && (dump_index == target)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_index_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_scan(input string tag, input int base);
        chk({tag, "_beats"}, 64'(n_beats - base), 64'(c_NREG));
        for (int k = 0; k < c_NREG; k++) begin
            chk({tag, "_idx"}, 64'(got_idx[base + k]), 64'(k));
            chk({tag, "_data"}, 64'(got_data[base + k]), 64'(exp_val(k)));
        end
    endtask

    task automatic full_scan(input string tag);
        int base = n_beats;
        int d0   = done_cnt;
        pulse_start;
        wait_done(tag);
        check_scan(tag, base);
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int base, d0, g0;
        rstb = 1'b0; start = 1'b0; abort = 1'b0;
        rdy_fixed = 1'b1; rdy_rand_en = 1'b0;
        req_fixed = 1'b0; req_rand_en = 1'b0;
        for (int n = 0; n < 32; n++) gpr_mem[n] = 32'(n) * 32'h0101_0101;
        for (int k = 0; k < 8; k++) ecr_mem[k] = 34'h2_0000_0000 | 34'(k);
        repeat (3) tick;

        // Reset values.
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_gpr_en", 64'(gpr_rd_en), 64'd0);
        chk("rst_ecr_en", 64'(ecr_rd_en), 64'd0);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_index", 64'(dump_index), 64'd0);
        chk("rst_data", 64'(dump_data), 64'd0);
        chk("rst_gpr_addr", 64'(gpr_rd_addr), 64'd0);
        chk("rst_ecr_addr", 64'(ecr_rd_addr), 64'd0);
        chk("rst_gnt", 64'(core_gnt), 64'd1);
        rstb = 1'b1;
        repeat (2) tick;

        // Uncontended scan with the patterned register contents.
        base = n_beats;
        full_scan("plain");
        chk("plain_beat5", 64'(got_data[base + 5]), 64'h0_0505_0505);
        chk("plain_beat35", 64'(got_data[base + 35]), 64'h2_0000_0003);
        chk("plain_latency", 64'(done_cyc - start_cyc), 64'(1 + c_NREG * 4));

        // Core holds the port throughout: each read is forced after starving.
        randomize_regs;
        req_fixed = 1'b1;
        g0 = gnt_low;
        full_scan("starve");
        chk("starve_gnt_low", 64'(gnt_low - g0), 64'(c_NREG));
        chk("starve_latency", 64'(done_cyc - start_cyc), 64'(1 + c_NREG * (c_STARVE + 4)));
        req_fixed = 1'b0;

        // Random backpressure and random core requests.
        randomize_regs;
        rdy_rand_en = 1'b1;
        req_rand_en = 1'b1;
        full_scan("random");
        rdy_rand_en = 1'b0;
        req_rand_en = 1'b0;
        chk("random_stability", 64'(stab_err), 64'd0);
        chk("hold_core_gnt", 64'(hold_gnt_err), 64'd0);
        chk("gnt_vs_strobe", 64'(gnt_rd_err), 64'd0);

        // Abort while index 12 is presented.
        randomize_regs;
        base = n_beats;
        d0   = done_cnt;
        pulse_start;
        wait_valid_idx(6'd12);
        abort = 1'b1;
        rdy_fixed = 1'b0;
        tick;
        abort = 1'b0;
        rdy_fixed = 1'b1;
        chk("abort_valid", 64'(dump_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (5) tick;
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_beats", 64'(n_beats - base), 64'd12);
        full_scan("after_abort");

        // Asynchronous reset at index 20.
        randomize_regs;
        pulse_start;
        wait_valid_idx(6'd20);
        #2 rstb = 1'b0;
        #1;
        chk("arst_valid", 64'(dump_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_index", 64'(dump_index), 64'd0);
        chk("arst_data", 64'(dump_data), 64'd0);
        chk("arst_gnt", 64'(core_gnt), 64'd1);
        start = 1'b1;
        repeat (3) tick;
        start = 1'b0;
        chk("arst_start_ignored", 64'(busy), 64'd0);
        rstb = 1'b1;
        tick;
        chk("arst_idle_after", 64'(busy), 64'd0);
        full_scan("after_reset");

        // Start re-pulsed mid-scan is ignored.
        randomize_regs;
        base = n_beats;
        d0   = done_cnt;
        pulse_start;
        wait_valid_idx(6'd3);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("repulse_busy", 64'(busy), 64'd1);
        wait_done("repulse");
        check_scan("repulse", base);
        chk("repulse_done_count", 64'(done_cnt - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
